// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding,
// FSM states and the small helpers used by the forwarding and stall logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } hz_state_t;

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 4.
  localparam int LAT_W = 2;

  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) begin
      return FWD_MEM;
    end else if (hit_w) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one Execute operand; the M-stage result wins over W.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] wa_m,
  input  logic [REG_W-1:0] wa_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output fwd_sel_t         sel
);

  logic hit_m_s;
  logic hit_w_s;

  // Compare the operand address against both in-flight writers.
  always_comb begin
    hit_m_s = regwrite_m && (ra == wa_m);
    hit_w_s = regwrite_w && (ra == wa_w);
    sel     = fwd_pick(hit_m_s, hit_w_s);
  end

endmodule

// File: rtl/pipe_hazard_ctrl_chk.sv
// Structural invariants of the hazard controller outputs.
module pipe_hazard_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic StallD,
  input logic StallEM,
  input logic FlushD,
  input logic FlushE,
  input logic FlushW
);

  a_memwait_shape: assert property (@(posedge clk) disable iff (reset)
    StallEM |-> (FlushW && !FlushE));

  a_flush_over_stall: assert property (@(posedge clk) disable iff (reset)
    !(StallD && FlushD));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stalls,
// memory-wait freezes, branch/PC-write flushes and a saturating stall counter.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic [2:0]       PCSrcPend,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallEM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t        state_r;
  hz_state_t        saved_r;
  hz_state_t        eff_state_s;
  logic [LAT_W-1:0] cnt_r;
  logic             memwait_s;
  logic             hit_s;
  logic             pc_pend_s;
  logic             ld_stall_s;
  logic             flush_d_s;
  fwd_sel_t         fwd_a_s;
  fwd_sel_t         fwd_b_s;

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .ra         (RA1E),
    .wa_m       (WA3M),
    .wa_w       (WA3W),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .sel        (fwd_a_s)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .ra         (RA2E),
    .wa_m       (WA3M),
    .wa_w       (WA3W),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .sel        (fwd_b_s)
  );

  // Hazard conditions; once a memory wait ends the saved state applies immediately.
  always_comb begin
    memwait_s = MemReqM && !MemReadyM;
    hit_s     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    pc_pend_s = |PCSrcPend;
    if (state_r == MEMWAIT) begin
      eff_state_s = saved_r;
    end else begin
      eff_state_s = state_r;
    end
    if (BranchTakenE) begin
      ld_stall_s = 1'b0;
    end else if (eff_state_s == LDSTALL) begin
      ld_stall_s = 1'b1;
    end else begin
      ld_stall_s = hit_s;
    end
    flush_d_s = BranchTakenE || pc_pend_s || PCSrcW;
  end

  // Output decode; reset forces the safe bubble pattern without waiting for a clock.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallEM   = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (memwait_s) begin
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallEM   = 1'b1;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b1;
    end else begin
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
      StallF    = ld_stall_s || pc_pend_s;
      StallD    = ld_stall_s && !flush_d_s;
      StallEM   = 1'b0;
      FlushD    = flush_d_s;
      FlushE    = BranchTakenE || ld_stall_s;
      FlushW    = 1'b0;
    end
  end

  // Stall FSM: MEMWAIT freezes the load-use counter and remembers where to resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      saved_r <= IDLE;
      cnt_r   <= {LAT_W{1'b0}};
    end else if (memwait_s) begin
      if (state_r != MEMWAIT) begin
        saved_r <= state_r;
      end
      state_r <= MEMWAIT;
    end else if (BranchTakenE) begin
      state_r <= IDLE;
      saved_r <= IDLE;
      cnt_r   <= {LAT_W{1'b0}};
    end else begin
      saved_r <= IDLE;
      case (eff_state_s)
        IDLE: begin
          if (hit_s && (LOAD_LAT > 1)) begin
            state_r <= LDSTALL;
            cnt_r   <= LAT_INIT;
          end else begin
            state_r <= IDLE;
          end
        end
        LDSTALL: begin
          if (cnt_r <= LAT_W'(1)) begin
            state_r <= IDLE;
            cnt_r   <= {LAT_W{1'b0}};
          end else begin
            state_r <= LDSTALL;
            cnt_r   <= cnt_r - LAT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {LAT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= {CNT_W{1'b0}};
    end else if (StallF && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

  pipe_hazard_ctrl_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .StallD  (StallD),
    .StallEM (StallEM),
    .FlushD  (FlushD),
    .FlushE  (FlushE),
    .FlushW  (FlushW)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a has LOAD_LAT=3/CNT_W=16, instance b LOAD_LAT=1/CNT_W=2.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic [2:0] PCSrcPend;

  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic        sf_a, sd_a, sem_a, fd_a, fe_a, fw_a;
  logic        sf_b, sd_b, sem_b, fd_b, fe_b, fw_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .LOAD_LAT(3), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcPend(PCSrcPend), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a), .StallEM(sem_a),
    .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a), .StallCnt(cnt_a)
  );

  pipe_hazard_ctrl #(.REG_W(4), .LOAD_LAT(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcPend(PCSrcPend), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b), .StallEM(sem_b),
    .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b), .StallCnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control vectors packed as {StallF, StallD, StallEM, FlushD, FlushE, FlushW}.
  function automatic logic [31:0] ctl_a();
    return {26'd0, sf_a, sd_a, sem_a, fd_a, fe_a, fw_a};
  endfunction

  function automatic logic [31:0] ctl_b();
    return {26'd0, sf_b, sd_b, sem_b, fd_b, fe_b, fw_b};
  endfunction

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0; PCSrcPend = 3'b000;
    PCSrcW = 1'b0; BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic load_use();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    MemReqM = 1'b1; PCSrcPend = 3'b111; RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    #2;
    check("reset_ctl_a", ctl_a(), 32'h07);
    check("reset_ctl_b", ctl_b(), 32'h07);
    check("reset_fwd_a", {30'd0, fa_a}, 32'd0);
    check("reset_cnt_a", {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1 check("idle_ctl", ctl_a(), 32'h00);

    // Forwarding priority.
    @(negedge clk);
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1 check("fwd_m_prio", {30'd0, fa_a}, 32'd2);
    RegWriteM = 1'b0;
    #1 check("fwd_w", {30'd0, fa_a}, 32'd1);
    RegWriteW = 1'b0;
    #1 check("fwd_rf", {30'd0, fa_a}, 32'd0);
    RA2E = 4'd7; WA3W = 4'd7; RegWriteW = 1'b1; RegWriteM = 1'b1;
    #1 check("fwd_a_mem", {30'd0, fa_a}, 32'd2);
    check("fwd_b_wb", {30'd0, fb_a}, 32'd1);

    // Load-use: three stalled cycles on a, one on b.
    @(negedge clk);
    clear_inputs();
    load_use();
    #1 check("lu_c1_a", ctl_a(), 32'h32);
    check("lu_c1_b", ctl_b(), 32'h32);
    @(negedge clk);
    MemtoRegE = 1'b0;
    #1 check("lu_c2_a", ctl_a(), 32'h32);
    check("lu_c2_b", ctl_b(), 32'h00);
    @(negedge clk);
    #1 check("lu_c3_a", ctl_a(), 32'h32);
    @(negedge clk);
    #1 check("lu_end_a", ctl_a(), 32'h00);
    check("lu_cnt_a", {16'd0, cnt_a}, 32'd3);
    check("lu_cnt_b", {30'd0, cnt_b}, 32'd1);

    // Memory wait of four cycles in the middle of LDSTALL.
    @(negedge clk);
    load_use();
    #1 check("mw_hit_a", ctl_a(), 32'h32);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemtoRegE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b0;
      #1 check($sformatf("mw_wait%0d_a", i), ctl_a(), 32'h39);
      check($sformatf("mw_wait%0d_b", i), ctl_b(), 32'h39);
    end
    @(negedge clk);
    MemReqM = 1'b0;
    #1 check("mw_resume1_a", ctl_a(), 32'h32);
    check("mw_resume1_b", ctl_b(), 32'h00);
    @(negedge clk);
    #1 check("mw_resume2_a", ctl_a(), 32'h32);
    @(negedge clk);
    #1 check("mw_end_a", ctl_a(), 32'h00);
    check("mw_cnt_a", {16'd0, cnt_a}, 32'd10);
    check("sat_cnt_b", {30'd0, cnt_b}, 32'd3);

    // Branch in the same cycle as a load-use hit.
    @(negedge clk);
    load_use();
    BranchTakenE = 1'b1;
    #1 check("br_hit_a", ctl_a(), 32'h06);
    check("br_hit_b", ctl_b(), 32'h06);
    @(negedge clk);
    clear_inputs();
    #1 check("br_after_a", ctl_a(), 32'h00);

    // Branch aborts a running LDSTALL.
    @(negedge clk);
    load_use();
    #1 check("abort_hit_a", ctl_a(), 32'h32);
    @(negedge clk);
    MemtoRegE = 1'b0; BranchTakenE = 1'b1;
    #1 check("abort_br_a", ctl_a(), 32'h06);
    @(negedge clk);
    clear_inputs();
    #1 check("abort_after_a", ctl_a(), 32'h00);

    // PC-write pending and PC written in W.
    @(negedge clk);
    PCSrcPend = 3'b010;
    #1 check("pcpend_a", ctl_a(), 32'h24);
    @(negedge clk);
    PCSrcPend = 3'b000; PCSrcW = 1'b1;
    #1 check("pcsrcw_a", ctl_a(), 32'h04);
    @(negedge clk);
    clear_inputs();
    #1 check("pc_cnt_a", {16'd0, cnt_a}, 32'd12);

    // Reset in the middle of LDSTALL.
    @(negedge clk);
    load_use();
    @(negedge clk);
    MemtoRegE = 1'b0;
    #1 check("rst_pre_a", ctl_a(), 32'h32);
    reset = 1'b1;
    #1 check("rst_mid_a", ctl_a(), 32'h07);
    check("rst_mid_b", ctl_b(), 32'h07);
    check("rst_mid_cnt_a", {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_after_a", ctl_a(), 32'h00);
    check("rst_after_cnt_a", {16'd0, cnt_a}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
REQ-002 REG_W, 4, register-address width.
REQ-003 LOAD_LAT, 1, load-use stall length in cycles; legal range 1..4.
REQ-004 CNT_W, 16, width of the stall performance counter.
REQ-005 Ports, one per line: name, direction, width, meaning. There is one clock; reset SHALL be asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 RA1D, RA2D  in  REG_W  source registers of the Decode instruction.
REQ-009 RA1E, RA2E  in  REG_W  source registers of the Execute instruction.
REQ-010 WA3E, WA3M, WA3W  in  REG_W  destination registers in E, M and W.
REQ-011 RegWriteM, RegWriteW  in  1  register-write enables in M and W.
REQ-012 MemtoRegE  in  1  the Execute instruction is a load.
REQ-013 PCSrcPend  in  3  PC write pending in D, E, M (bits 2:0).
REQ-014 PCSrcW  in  1  PC written in Writeback.
REQ-015 BranchTakenE  in  1  branch resolved taken in Execute.
REQ-016 MemReqM  in  1  M-stage data-memory access active.
REQ-017 MemReadyM  in  1  data memory completes this cycle.
REQ-018 ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 ResultW, 10 ALUOutM.
REQ-019 StallF, StallD, StallEM  out  1  hold the F, D, and E+M pipeline registers.
REQ-020 FlushD, FlushE, FlushW  out  1  clear the D, E and W pipeline registers.
REQ-021 StallCnt  out  CNT_W  count of stalled cycles, saturating.

Function
REQ-022 Forwarding, per operand (A uses RA1E, B uses RA2E): select 10 if RAxE==WA3M and RegWriteM; else 01 if RAxE==WA3W and RegWriteW; else 00. M has priority over W.
REQ-023 Load-use hit: MemtoRegE and (WA3E==RA1D or WA3E==RA2D).
REQ-024 FSM states: IDLE, LDSTALL, MEMWAIT.
REQ-025 IDLE->LDSTALL on a load-use hit with LOAD_LAT>1 and no BranchTakenE; the down-counter loads LOAD_LAT-1.
REQ-026 In the hit cycle and each LDSTALL cycle: StallF=StallD=1, FlushE=1. LDSTALL->IDLE when the counter reaches 0, giving exactly LOAD_LAT stall cycles total.
REQ-027 Memory wait (MemReqM and !MemReadyM): StallF=StallD=StallEM=1, FlushW=1, FlushE=0.
REQ-028 Memory wait enters MEMWAIT from any state and returns to the saved state when it ends; the LDSTALL counter is frozen while in MEMWAIT. Memory wait has the highest priority.
REQ-029 BranchTakenE (no memory wait): FlushD=FlushE=1; the load-use hit is suppressed; LDSTALL is aborted to IDLE.
REQ-030 Outside memory wait: StallF |= any PCSrcPend bit; FlushD |= (|PCSrcPend) | PCSrcW; a flush overrides a stall on the same register.
REQ-031 StallCnt increments once per cycle in which StallF=1 and saturates at all-ones.

Reset
REQ-032 While reset is asserted: state=IDLE, counters=0, StallCnt=0, Forward*=00, all Stall*=0, FlushD=FlushE=FlushW=1. Reset asserted mid-stall SHALL abort the stall immediately.

Structure
REQ-033 Package hazard_pkg SHALL hold fwd_sel_t (FWD_RF, FWD_WB, FWD_MEM) and hz_state_t.
REQ-034 The sub-module hazard_fwd_sel (one operand's forward select) SHALL be instantiated twice.

Verification
REQ-035 Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-036 Load-use: LOAD_LAT=3, WA3E=5, RA2D=5, MemtoRegE=1 -> StallF, StallD and FlushE high for exactly 3 cycles; StallCnt=3.
REQ-037 Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles during LDSTALL -> StallEM=1 and FlushW=1 for 4 cycles; LDSTALL resumes with the counter unchanged.
REQ-038 Branch and load-use in the same cycle -> FlushD=FlushE=1, StallF=0, state stays IDLE.
REQ-039 CNT_W=2 with 5 stall cycles -> StallCnt=3; reset asserted mid-LDSTALL -> all Stall*=0 and FlushD=FlushE=FlushW=1 in the same cycle.
